decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
// - RV32I instruction-decode stage sitting between the IF/ID latch and the execute stage.
// - Drives the register_file read addresses (rs1/rs2) and samples the returned read data.
// - Generates immediates and control signals, and detects load-use hazards (stall + bubble).
// - Owns the ID/EX pipeline register that feeds execute.
// PARAMETERS
// - DATA_WIDTH  32  datapath / register width
// - ADDR_WIDTH  5   register index width (32 registers)
// PORTS
// - clk          in   1           pipeline clock, rising edge
// - rst          in   1           asynchronous reset, active-high
// - if_valid     in   1           IF/ID holds a valid instruction
// - if_instr     in   32          instruction word
// - if_pc        in   32          PC of if_instr
// - flush        in   1           branch/jump taken in EX; kill the decode slot
// - rf_raddr1    out  ADDR_WIDTH  rs1 index to register file (if_instr[19:15])
// - rf_raddr2    out  ADDR_WIDTH  rs2 index to register file (if_instr[24:20])
// - rf_rdata1    in   DATA_WIDTH  rs1 data from register file
// - rf_rdata2    in   DATA_WIDTH  rs2 data from register file
// - wb_reg_wr    in   1           writeback write enable (used by the bypass)
// - wb_waddr     in   ADDR_WIDTH  writeback destination register
// - wb_wdata     in   DATA_WIDTH  writeback data
// - stall        out  1           hold PC and IF/ID this cycle (combinational)
// - ex_valid     out  1           ID/EX slot valid
// - ex_pc        out  32          PC of the instruction in EX
// - ex_rs1_data  out  DATA_WIDTH  operand 1
// - ex_rs2_data  out  DATA_WIDTH  operand 2
// - ex_imm       out  DATA_WIDTH  sign-extended immediate
// - ex_rs1, ex_rs2, ex_rd  out  ADDR_WIDTH  register indices (for forwarding in EX)
// - ex_opcode    out  7           opcode field
// - ex_funct3    out  3           funct3 field
// - ex_funct7b5  out  1           instr[30]
// - ex_reg_wr    out  1           EX instruction writes rd (forced 0 when rd==0)
// - ex_mem_rd    out  1           EX instruction is a load
// - ex_mem_wr    out  1           EX instruction is a store
// - ex_illegal   out  1           unrecognised opcode
// BEHAVIOUR
// - Reset (async, rst=1): all ex_* registers are 0, so stall=0. Reset takes effect
//   mid-instruction immediately; the first post-reset edge loads normally.
// - Latency: 1 cycle. Each rising edge captures decode of if_instr into ID/EX.
// - Immediates: I / S / B / U / J per opcode, sign-extended from instr[31];
//   B and J immediates have bit0 = 0; U = {instr[31:12], 12'b0}; R-type imm = 0.
// - Register usage:
//   - rs1 used by all except LUI, AUIPC, JAL.
//   - rs2 used only by R-type, STORE and BRANCH.
//   - An unused rs is reported as 0.
// - Load-use hazard: stall=1 iff if_valid && ex_valid && ex_mem_rd && ex_rd!=0
//   && (ex_rd==rs1 used || ex_rd==rs2 used).
//   - While stalled: a bubble is loaded (ex_valid=0, all control 0); upstream holds.
//   - The stall lasts exactly 1 cycle, because the bubble clears ex_mem_rd.
// - flush=1 at an edge: load a bubble regardless of if_valid. stall is forced to 0
//   while flush=1 (flush has priority).
// - if_valid=0: load a bubble.
// - Illegal opcode: ex_valid=1, ex_illegal=1, and reg_wr / mem_rd / mem_wr = 0.
// - ex_reg_wr=0 for STORE and BRANCH, and whenever rd==0.
// - Bubble slots drive data fields to 0.
// CONFIGURATION
// - DECODE_WB_BYPASS_EN defined:
//   - If wb_reg_wr && wb_waddr!=0 && wb_waddr==rsN, then ex_rsN_data captures
//     wb_wdata instead of rf_rdataN.
//   - This makes the stage correct with a posedge-writing register file.
// - Undefined: operands come straight from rf_rdata1/2; wb_* ports are ignored.
//   Same-cycle write visibility relies on the register file's negedge write.
// TESTING
// - addi x5,x1,7 (0x00708293) with rf_rdata1=2 -> next edge: ex_valid=1, ex_rs1_data=2,
//   ex_imm=7, ex_rd=5, ex_reg_wr=1.
// - lw x6,0(x2) then add x7,x6,x1 -> stall=1 for 1 cycle, a bubble appears in EX,
//   then the add issues with ex_rs1=6.
// - lw x6,0(x2) then lui x6,1 -> no stall; lui does not read rs1.
// - beq with imm=-4 (0xFE000EE3) -> ex_imm=0xFFFFFFFC, ex_reg_wr=0; flush the same
//   cycle -> ex_valid=0.
// - Assert rst while ex_valid=1 and a load is in EX -> all ex_* =0 and stall=0
//   asynchronously.
// - DECODE_WB_BYPASS_EN: wb writes x10=0x55 while add x11,x10,x0 decodes with stale
//   rf_rdata1=10 -> ex_rs1_data=0x55.

Source files
------------

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// RV32I instruction decode stage, placed between the IF/ID latch and execute.
// It drives the register-file read addresses, decodes immediates and control
// signals, detects load-use hazards and owns the ID/EX pipeline register.
//
// Optional feature macro: DECODE_WB_BYPASS_EN
//   defined   : a same-cycle writeback to rs1/rs2 (rd != x0) overrides the
//               register-file read data, for register files that write on posedge.
//   undefined : operands come straight from rf_rdata1/2 and wb_* are ignored.
//
// Ports
//   clk, rst               clock (rising edge) and async active-high reset
//   if_valid/instr/pc      IF/ID contents
//   flush                  kill the decode slot (taken branch/jump in EX)
//   rf_raddr1/2            rs1/rs2 indices to the register file
//   rf_rdata1/2            register-file read data
//   wb_reg_wr/waddr/wdata  writeback port (bypass only)
//   stall                  combinational load-use stall (hold PC and IF/ID)
//   ex_*                   ID/EX pipeline register outputs
//
// Handshake: there is no valid/ready pair here. if_valid qualifies the IF/ID
// slot; stall is this stage's back-pressure to fetch and means "the slot was
// not consumed this cycle, present it again". ex_valid qualifies the ID/EX slot.
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [31:0]           if_instr,
    input  logic [31:0]           if_pc,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] rf_raddr1,
    output logic [ADDR_WIDTH-1:0] rf_raddr2,
    input  logic [DATA_WIDTH-1:0] rf_rdata1,
    input  logic [DATA_WIDTH-1:0] rf_rdata2,
    input  logic                  wb_reg_wr,
    input  logic [ADDR_WIDTH-1:0] wb_waddr,
    input  logic [DATA_WIDTH-1:0] wb_wdata,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [31:0]           ex_pc,
    output logic [DATA_WIDTH-1:0] ex_rs1_data,
    output logic [DATA_WIDTH-1:0] ex_rs2_data,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [ADDR_WIDTH-1:0] ex_rs1,
    output logic [ADDR_WIDTH-1:0] ex_rs2,
    output logic [ADDR_WIDTH-1:0] ex_rd,
    output logic [6:0]            ex_opcode,
    output logic [2:0]            ex_funct3,
    output logic                  ex_funct7b5,
    output logic                  ex_reg_wr,
    output logic                  ex_mem_rd,
    output logic                  ex_mem_wr,
    output logic                  ex_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Instruction fields
    logic [6:0]            opcode;
    logic [ADDR_WIDTH-1:0] rd_f;
    logic [ADDR_WIDTH-1:0] rs1_f;
    logic [ADDR_WIDTH-1:0] rs2_f;

    assign opcode = if_instr[6:0];
    assign rd_f   = if_instr[11:7];
    assign rs1_f  = if_instr[19:15];
    assign rs2_f  = if_instr[24:20];

    assign rf_raddr1 = rs1_f;
    assign rf_raddr2 = rs2_f;

    // Decoded control
    logic        legal;
    logic        rs1_used;
    logic        rs2_used;
    logic        is_load;
    logic        is_store;
    logic        writes_rd;
    logic [31:0] imm32;

    always_comb begin
        legal     = 1'b1;
        rs1_used  = 1'b1;
        rs2_used  = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        writes_rd = 1'b1;
        imm32     = 32'd0;
        unique case (opcode)
            OP_REG: begin
                rs2_used = 1'b1;
            end
            OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM: begin
                imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OP_LOAD: begin
                is_load = 1'b1;
                imm32   = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OP_STORE: begin
                rs2_used  = 1'b1;
                is_store  = 1'b1;
                writes_rd = 1'b0;
                imm32     = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            end
            OP_BRANCH: begin
                rs2_used  = 1'b1;
                writes_rd = 1'b0;
                imm32     = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                             if_instr[30:25], if_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                rs1_used = 1'b0;
                imm32    = {if_instr[31:12], 12'd0};
            end
            OP_JAL: begin
                rs1_used = 1'b0;
                imm32    = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                            if_instr[20], if_instr[30:21], 1'b0};
            end
            default: begin
                // Unrecognised opcode: travels down the pipe flagged illegal
                // with every side effect suppressed.
                legal     = 1'b0;
                writes_rd = 1'b0;
            end
        endcase
    end

    // Source indices as reported to EX (unused sources read as x0)
    logic [ADDR_WIDTH-1:0] src1;
    logic [ADDR_WIDTH-1:0] src2;

    assign src1 = rs1_used ? rs1_f : '0;
    assign src2 = rs2_used ? rs2_f : '0;

    // Operand selection
    logic [DATA_WIDTH-1:0] opnd1;
    logic [DATA_WIDTH-1:0] opnd2;

`ifdef DECODE_WB_BYPASS_EN
    logic wb_hit1;
    logic wb_hit2;

    assign wb_hit1 = wb_reg_wr && (wb_waddr != '0) && (wb_waddr == rs1_f);
    assign wb_hit2 = wb_reg_wr && (wb_waddr != '0) && (wb_waddr == rs2_f);
    assign opnd1   = !rs1_used ? '0 : (wb_hit1 ? wb_wdata : rf_rdata1);
    assign opnd2   = !rs2_used ? '0 : (wb_hit2 ? wb_wdata : rf_rdata2);
`else
    // Writeback port is not consumed in this build.
    logic wb_unused;

    assign wb_unused = ^{wb_reg_wr, wb_waddr, wb_wdata};
    assign opnd1     = rs1_used ? rf_rdata1 : '0;
    assign opnd2     = rs2_used ? rf_rdata2 : '0;
`endif

    // Load-use hazard: the load in EX has no data until MEM, so the
    // dependent instruction waits one cycle behind a bubble. The bubble
    // clears ex_mem_rd, which ends the stall on the following cycle.
    logic load_use;

    assign load_use = ex_valid && ex_mem_rd && (ex_rd != '0) &&
                      ((ex_rd == src1) || (ex_rd == src2));
    assign stall    = if_valid && !flush && load_use;

    logic bubble;

    assign bubble = flush || !if_valid || stall;

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_reg_wr   <= 1'b0;
            ex_mem_rd   <= 1'b0;
            ex_mem_wr   <= 1'b0;
            ex_illegal  <= 1'b0;
        end else if (bubble) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_reg_wr   <= 1'b0;
            ex_mem_rd   <= 1'b0;
            ex_mem_wr   <= 1'b0;
            ex_illegal  <= 1'b0;
        end else begin
            ex_valid    <= 1'b1;
            ex_pc       <= if_pc;
            ex_rs1_data <= opnd1;
            ex_rs2_data <= opnd2;
            ex_imm      <= DATA_WIDTH'($signed(imm32));
            ex_rs1      <= src1;
            ex_rs2      <= src2;
            ex_rd       <= rd_f;
            ex_opcode   <= opcode;
            ex_funct3   <= if_instr[14:12];
            ex_funct7b5 <= if_instr[30];
            ex_reg_wr   <= writes_rd && (rd_f != '0);
            ex_mem_rd   <= is_load;
            ex_mem_wr   <= is_store;
            ex_illegal  <= !legal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//
// Bench for decode_stage: a table of directed vectors, hand-written sequences
// for async reset and the writeback bypass, then randomized instructions
// checked against a format-level reference model.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = 32'd0;
    logic [31:0] if_pc    = 32'd0;
    logic        flush    = 1'b0;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1 = 32'd0;
    logic [31:0] rf_rdata2 = 32'd0;
    logic        wb_reg_wr = 1'b0;
    logic [4:0]  wb_waddr  = 5'd0;
    logic [31:0] wb_wdata  = 32'd0;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_illegal;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_reg_wr(wb_reg_wr), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
        .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_illegal(ex_illegal)
    );

    // ---------------------------------------------------------------- scoreboard
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        valid;
        logic [31:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5, reg_wr, mem_rd, mem_wr, illegal;
    } ex_t;

    task automatic check_ex(input string tag, input ex_t e);
        chk({tag, " ex_valid"},    ex_valid,    e.valid);
        chk({tag, " ex_pc"},       ex_pc,       e.pc);
        chk({tag, " ex_rs1_data"}, ex_rs1_data, e.rs1_data);
        chk({tag, " ex_rs2_data"}, ex_rs2_data, e.rs2_data);
        chk({tag, " ex_imm"},      ex_imm,      e.imm);
        chk({tag, " ex_rs1"},      ex_rs1,      e.rs1);
        chk({tag, " ex_rs2"},      ex_rs2,      e.rs2);
        chk({tag, " ex_rd"},       ex_rd,       e.rd);
        chk({tag, " ex_opcode"},   ex_opcode,   e.opcode);
        chk({tag, " ex_funct3"},   ex_funct3,   e.funct3);
        chk({tag, " ex_funct7b5"}, ex_funct7b5, e.funct7b5);
        chk({tag, " ex_reg_wr"},   ex_reg_wr,   e.reg_wr);
        chk({tag, " ex_mem_rd"},   ex_mem_rd,   e.mem_rd);
        chk({tag, " ex_mem_wr"},   ex_mem_wr,   e.mem_wr);
        chk({tag, " ex_illegal"},  ex_illegal,  e.illegal);
    endtask

    // ---------------------------------------------------------------- reference model
    // Instruction classes by format letter; the model then builds the immediate
    // arithmetically from the instruction word.
    ex_t mdl_ex;

    function automatic byte fmt_of(input logic [6:0] op);
        case (op)
            7'h33:                      return "R";
            7'h13, 7'h67, 7'h03,
            7'h0F, 7'h73:               return "I";
            7'h23:                      return "S";
            7'h63:                      return "B";
            7'h37, 7'h17:               return "U";
            7'h6F:                      return "J";
            default:                    return "X";
        endcase
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] ins);
        int sgn;
        int v;
        sgn = $signed(ins) >>> 31;   // 0 or -1
        case (fmt_of(ins[6:0]))
            "I": v = $signed(ins) >>> 20;
            "S": v = sgn * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:7]);
            "B": v = sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                     + int'(ins[11:8]) * 2;
            "U": v = int'(ins & 32'hFFFF_F000);
            "J": v = sgn * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                     + int'(ins[30:21]) * 2;
            default: v = 0;
        endcase
        return v;
    endfunction

    // Index of a source register as it is read, or 0 when the instruction
    // does not read that source.
    function automatic logic [4:0] src1_of(input logic [31:0] ins);
        byte f;
        f = fmt_of(ins[6:0]);
        if (f == "U" || f == "J") return 5'd0;
        return ins[19:15];
    endfunction

    function automatic logic [4:0] src2_of(input logic [31:0] ins);
        byte f;
        f = fmt_of(ins[6:0]);
        if (f == "R" || f == "S" || f == "B") return ins[24:20];
        return 5'd0;
    endfunction

    function automatic logic model_stall(input logic [31:0] ins, input logic v, input logic fl);
        if (!v || fl) return 1'b0;
        if (!(mdl_ex.valid && mdl_ex.mem_rd) || mdl_ex.rd == 5'd0) return 1'b0;
        return (mdl_ex.rd == src1_of(ins)) || (mdl_ex.rd == src2_of(ins));
    endfunction

    function automatic ex_t model_next(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic v, input logic fl, input logic st,
                                       input logic [31:0] r1, input logic [31:0] r2,
                                       input logic wbw, input logic [4:0] wba,
                                       input logic [31:0] wbd);
        ex_t e;
        byte f;
        e = '{default: 0};
        if (!v || fl || st) return e;
        f = fmt_of(ins[6:0]);
        e.valid    = 1'b1;
        e.pc       = pc;
        e.rs1      = src1_of(ins);
        e.rs2      = src2_of(ins);
        e.rd       = ins[11:7];
        e.opcode   = ins[6:0];
        e.funct3   = ins[14:12];
        e.funct7b5 = ins[30];
        e.imm      = imm_of(ins);
        e.illegal  = (f == "X");
        e.mem_rd   = (ins[6:0] == 7'h03);
        e.mem_wr   = (ins[6:0] == 7'h23);
        e.reg_wr   = !(f == "X" || f == "S" || f == "B") && (ins[11:7] != 5'd0);
        e.rs1_data = (f == "U" || f == "J") ? 32'd0 : r1;
        e.rs2_data = (f == "R" || f == "S" || f == "B") ? r2 : 32'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (wbw && wba != 5'd0 && f != "U" && f != "J" && wba == ins[19:15])
            e.rs1_data = wbd;
        if (wbw && wba != 5'd0 && (f == "R" || f == "S" || f == "B") && wba == ins[24:20])
            e.rs2_data = wbd;
`else
        if (wbw && wba == 5'h1F && wbd == 32'hFFFF_FFFF) e.rs1_data = e.rs1_data; // wb ignored
`endif
        return e;
    endfunction

    // ---------------------------------------------------------------- driver
    task automatic apply(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                         input logic fl, input logic [31:0] r1, input logic [31:0] r2,
                         input logic wbw, input logic [4:0] wba, input logic [31:0] wbd);
        @(negedge clk);
        if_instr  = ins;
        if_pc     = pc;
        if_valid  = v;
        flush     = fl;
        rf_rdata1 = r1;
        rf_rdata2 = r2;
        wb_reg_wr = wbw;
        wb_waddr  = wba;
        wb_wdata  = wbd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- directed table
    typedef struct {
        logic [31:0] instr;
        logic        valid, flush;
        logic [31:0] rd1, rd2;
        logic        e_stall, e_valid;
        logic [31:0] e_imm, e_rs1_data, e_rs2_data;
        logic [4:0]  e_rs1, e_rs2, e_rd;
        logic        e_reg_wr, e_mem_rd, e_mem_wr, e_illegal;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    initial begin
        vec_t v;
        logic [31:0] pc;
        logic        held;
        logic        est;
        ex_t         e;
        logic [31:0] ins;
        logic [6:0]  ops[10];
        logic        rv, rfl, wbw;
        logic [31:0] r1, r2, wbd;
        logic [4:0]  wba;

        //            instr          v  f  rd1     rd2      st val imm          rs1d    rs2d    rs1 rs2 rd  rw mr mw il
        vecs[0]  = '{32'h00708293, 1, 0, 32'h2,  32'h22, 0, 1, 32'h7,        32'h2,  32'h0,  1, 0, 5,  1, 0, 0, 0};
        vecs[1]  = '{32'h00012303, 1, 0, 32'h11, 32'h22, 0, 1, 32'h0,        32'h11, 32'h0,  2, 0, 6,  1, 1, 0, 0};
        vecs[2]  = '{32'h001303B3, 1, 0, 32'h11, 32'h22, 1, 0, 32'h0,        32'h0,  32'h0,  0, 0, 0,  0, 0, 0, 0};
        vecs[3]  = '{32'h001303B3, 1, 0, 32'h11, 32'h22, 0, 1, 32'h0,        32'h11, 32'h22, 6, 1, 7,  1, 0, 0, 0};
        vecs[4]  = '{32'h00012303, 1, 0, 32'h11, 32'h22, 0, 1, 32'h0,        32'h11, 32'h0,  2, 0, 6,  1, 1, 0, 0};
        vecs[5]  = '{32'h00001337, 1, 0, 32'h11, 32'h22, 0, 1, 32'h1000,     32'h0,  32'h0,  0, 0, 6,  1, 0, 0, 0};
        vecs[6]  = '{32'h00012303, 1, 0, 32'h11, 32'h22, 0, 1, 32'h0,        32'h11, 32'h0,  2, 0, 6,  1, 1, 0, 0};
        vecs[7]  = '{32'h00612423, 1, 0, 32'h11, 32'h22, 1, 0, 32'h0,        32'h0,  32'h0,  0, 0, 0,  0, 0, 0, 0};
        vecs[8]  = '{32'h00612423, 1, 0, 32'h11, 32'h22, 0, 1, 32'h8,        32'h11, 32'h22, 2, 6, 8,  0, 0, 1, 0};
        vecs[9]  = '{32'hFE000EE3, 1, 0, 32'h11, 32'h22, 0, 1, 32'hFFFFFFFC, 32'h11, 32'h22, 0, 0, 29, 0, 0, 0, 0};
        vecs[10] = '{32'hFE000EE3, 1, 1, 32'h11, 32'h22, 0, 0, 32'h0,        32'h0,  32'h0,  0, 0, 0,  0, 0, 0, 0};
        vecs[11] = '{32'h00012303, 1, 0, 32'h11, 32'h22, 0, 1, 32'h0,        32'h11, 32'h0,  2, 0, 6,  1, 1, 0, 0};
        vecs[12] = '{32'h001303B3, 1, 1, 32'h11, 32'h22, 0, 0, 32'h0,        32'h0,  32'h0,  0, 0, 0,  0, 0, 0, 0};
        vecs[13] = '{32'h001303B3, 0, 0, 32'h11, 32'h22, 0, 0, 32'h0,        32'h0,  32'h0,  0, 0, 0,  0, 0, 0, 0};
        vecs[14] = '{32'h008000EF, 1, 0, 32'h11, 32'h22, 0, 1, 32'h8,        32'h0,  32'h0,  0, 0, 1,  1, 0, 0, 0};
        vecs[15] = '{32'h0000007F, 1, 0, 32'h0,  32'h22, 0, 1, 32'h0,        32'h0,  32'h0,  0, 0, 0,  0, 0, 0, 1};
        vecs[16] = '{32'h00000013, 1, 0, 32'h11, 32'h22, 0, 1, 32'h0,        32'h11, 32'h0,  0, 0, 0,  0, 0, 0, 0};

        // -------- reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ex_valid", ex_valid, 0);
        chk("reset ex_mem_rd", ex_mem_rd, 0);
        chk("reset ex_pc", ex_pc, 0);
        chk("reset stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;

        // -------- directed table
        for (int i = 0; i < NV; i++) begin
            v  = vecs[i];
            pc = 32'h1000 + 32'(i) * 4;
            apply(v.instr, pc, v.valid, v.flush, v.rd1, v.rd2, 1'b0, 5'd0, 32'd0);
            chk($sformatf("vec%0d stall", i), stall, v.e_stall);
            tick();
            chk($sformatf("vec%0d ex_valid", i),    ex_valid,    v.e_valid);
            chk($sformatf("vec%0d ex_pc", i),       ex_pc,       v.e_valid ? pc : 32'd0);
            chk($sformatf("vec%0d ex_imm", i),      ex_imm,      v.e_imm);
            chk($sformatf("vec%0d ex_rs1_data", i), ex_rs1_data, v.e_rs1_data);
            chk($sformatf("vec%0d ex_rs2_data", i), ex_rs2_data, v.e_rs2_data);
            chk($sformatf("vec%0d ex_rs1", i),      ex_rs1,      v.e_rs1);
            chk($sformatf("vec%0d ex_rs2", i),      ex_rs2,      v.e_rs2);
            chk($sformatf("vec%0d ex_rd", i),       ex_rd,       v.e_rd);
            chk($sformatf("vec%0d ex_reg_wr", i),   ex_reg_wr,   v.e_reg_wr);
            chk($sformatf("vec%0d ex_mem_rd", i),   ex_mem_rd,   v.e_mem_rd);
            chk($sformatf("vec%0d ex_mem_wr", i),   ex_mem_wr,   v.e_mem_wr);
            chk($sformatf("vec%0d ex_illegal", i),  ex_illegal,  v.e_illegal);
        end

        // -------- async reset with a load in EX and a dependent add in decode
        apply(32'h00012303, 32'h2000, 1, 0, 32'h11, 32'h22, 0, 0, 0);
        tick();
        apply(32'h001303B3, 32'h2004, 1, 0, 32'h11, 32'h22, 0, 0, 0);
        chk("arst pre stall", stall, 1);
        chk("arst pre ex_mem_rd", ex_mem_rd, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst ex_valid", ex_valid, 0);
        chk("arst ex_mem_rd", ex_mem_rd, 0);
        chk("arst ex_rd", ex_rd, 0);
        chk("arst ex_pc", ex_pc, 0);
        chk("arst stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;
        apply(32'h00708293, 32'h2008, 1, 0, 32'h2, 32'h22, 0, 0, 0);
        tick();
        chk("post-rst ex_valid", ex_valid, 1);
        chk("post-rst ex_rd", ex_rd, 5);
        chk("post-rst ex_pc", ex_pc, 32'h2008);

        // -------- writeback bypass: add x11,x10,x0 with wb x10=0x55, stale rf=10
        apply(32'h000505B3, 32'h3000, 1, 0, 32'd10, 32'd0, 1, 5'd10, 32'h55);
        tick();
`ifdef DECODE_WB_BYPASS_EN
        chk("bypass ex_rs1_data", ex_rs1_data, 32'h55);
`else
        chk("no-bypass ex_rs1_data", ex_rs1_data, 32'd10);
`endif
        chk("bypass ex_rd", ex_rd, 11);
        // Writeback to x0 must never bypass.
        apply(32'h000005B3, 32'h3004, 1, 0, 32'd7, 32'd0, 1, 5'd0, 32'h99);
        tick();
        chk("wb x0 ex_rs1_data", ex_rs1_data, 32'd7);

        // -------- randomized run against the model
        rst = 1'b1;
        #2;
        rst = 1'b0;
        mdl_ex = '{default: 0};
        ops = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
        held = 1'b0;
        ins = 32'd0;
        pc  = 32'h4000;
        rv  = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!held) begin
                int k;
                ins = $urandom;
                k = $urandom_range(0, 10);
                ins[6:0]   = (k == 10) ? 7'($urandom) : ops[k];
                ins[11:7]  = 5'($urandom_range(0, 3));
                ins[19:15] = 5'($urandom_range(0, 3));
                ins[24:20] = 5'($urandom_range(0, 3));
                pc  = pc + 4;
                rv  = ($urandom_range(0, 99) < 85);
            end
            rfl = ($urandom_range(0, 99) < 10);
            r1  = $urandom;
            r2  = $urandom;
            wbw = $urandom_range(0, 1) == 1;
            wba = 5'($urandom_range(0, 3));
            wbd = $urandom;
            apply(ins, pc, rv, rfl, r1, r2, wbw, wba, wbd);
            est = model_stall(ins, rv, rfl);
            chk($sformatf("rand%0d stall", n), stall, est);
            e = model_next(ins, pc, rv, rfl, est, r1, r2, wbw, wba, wbd);
            tick();
            check_ex($sformatf("rand%0d", n), e);
            mdl_ex = e;
            held = est;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
